// File: rtl/spi_mstr.sv
// 16-bit mode-3 SPI master for the gain DACs, trigger DAC and calibration EEPROM.
// One frame per accepted wrt_SPI; the low received byte is returned on EEP_data.

package spi_mstr_pkg;

  // Target selection driven by the command dispatcher.
  typedef enum logic [2:0] {
    SS_NONE    = 3'd0,
    SS_CH1     = 3'd1,
    SS_CH2     = 3'd2,
    SS_CH3     = 3'd3,
    SS_TRIGGER = 3'd4,
    SS_EEPROM  = 3'd5
  } ss_t;

endpackage

module spi_mstr
  import spi_mstr_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt_SPI,
  input  logic [15:0] SPI_data,
  input  ss_t         ss,
  input  logic        MISO,
  output logic        SCLK,
  output logic        MOSI,
  output logic [4:0]  SS_n,
  output logic        SPI_done,
  output logic [7:0]  EEP_data,
  output logic        busy
);

  localparam int unsigned DW   = 16;
  localparam int unsigned SW   = 5;
  localparam int unsigned BW   = 4;
  localparam int unsigned EW   = 8;
  localparam int unsigned HALF = SCLK_DIV / 2;
  localparam int unsigned CW   = $clog2(SCLK_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRONT = 2'd1,
    SHIFT = 2'd2,
    BACK  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [BW-1:0]   bit_idx, bit_nxt;
  logic [DW-1:0]   tx, tx_nxt;
  logic [DW-1:0]   rx, rx_nxt;
  logic [SW-1:0]   sel, sel_nxt;
  logic            sclk_nxt;
  logic            mosi_nxt;
  logic [SW-1:0]   ss_n_nxt;
  logic            done_nxt;
  logic [EW-1:0]   eep_nxt;
  logic            busy_nxt;

  // One-hot select decode; SS_NONE and unused codes select nothing.
  function automatic logic [SW-1:0] decode_ss(input ss_t s);
    logic [SW-1:0] oh;
    oh = '0;
    case (s)
      SS_CH1:     oh = SW'(5'b00001);
      SS_CH2:     oh = SW'(5'b00010);
      SS_CH3:     oh = SW'(5'b00100);
      SS_TRIGGER: oh = SW'(5'b01000);
      SS_EEPROM:  oh = SW'(5'b10000);
      default:    oh = '0;
    endcase
    return oh;
  endfunction

  // State, datapath and registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      tx       <= '0;
      rx       <= '0;
      sel      <= '0;
      SCLK     <= 1'b1;
      MOSI     <= 1'b0;
      SS_n     <= '1;
      SPI_done <= 1'b0;
      EEP_data <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_nxt;
      tx       <= tx_nxt;
      rx       <= rx_nxt;
      sel      <= sel_nxt;
      SCLK     <= sclk_nxt;
      MOSI     <= mosi_nxt;
      SS_n     <= ss_n_nxt;
      SPI_done <= done_nxt;
      EEP_data <= eep_nxt;
      busy     <= busy_nxt;
    end
  end

  // Frame sequencing; pin values are decoded from the next state so they register alongside it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    tx_nxt    = tx;
    rx_nxt    = rx;
    sel_nxt   = sel;
    done_nxt  = 1'b0;
    eep_nxt   = EEP_data;
    busy_nxt  = busy;

    case (state)
      IDLE: begin
        if (wrt_SPI) begin
          state_nxt = FRONT;
          cnt_nxt   = '0;
          bit_nxt   = '0;
          tx_nxt    = SPI_data;
          rx_nxt    = '0;
          sel_nxt   = decode_ss(ss);
          busy_nxt  = 1'b1;
        end
      end
      FRONT: begin
        if (cnt == CW'(HALF - 1)) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      SHIFT: begin
        // First high cycle of the period: capture MISO.
        if (cnt == CW'(HALF)) begin
          rx_nxt = {rx[DW-2:0], MISO};
        end
        if (cnt == CW'(SCLK_DIV - 1)) begin
          cnt_nxt = '0;
          if (bit_idx == BW'(DW - 1)) begin
            state_nxt = BACK;
          end else begin
            bit_nxt = bit_idx + BW'(1);
            tx_nxt  = {tx[DW-2:0], 1'b0};
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      BACK: begin
        if (cnt == CW'(HALF - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          sel_nxt   = '0;
          done_nxt  = 1'b1;
          eep_nxt   = rx[EW-1:0];
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    sclk_nxt = !((state_nxt == SHIFT) && (cnt_nxt < CW'(HALF)));
    mosi_nxt = (state_nxt == IDLE) ? 1'b0 : tx_nxt[DW-1];
    ss_n_nxt = (state_nxt == IDLE) ? '1 : ~sel_nxt;
  end

endmodule
